shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//  Parametrised universal shift register, next generation of the 4-mode shift_reg4 family.
//  A command (op + amount) is accepted over a valid/ready handshake and executed one bit per
//  enabled cycle. Busy/done status and a serial-out tap let it feed serialisers and bit-stream
//  formatters in the shifter subsystem.
// PARAMETERS
//  WIDTH   8                      data width, >= 2
//  AMT_W   $clog2(WIDTH)+1        width of shift amount; max amount = 2**AMT_W-1 steps
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-low reset
//  enable     in   1       global advance; low = freeze all state
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command can be accepted (= state==IDLE && enable)
//  cmd_op     in   3       operation, shift_op_e
//  cmd_amt    in   AMT_W   number of one-bit steps (shift ops only)
//  data_in    in   WIDTH   parallel load value (LOAD only)
//  ser_in     in   1       fill bit for SHL/SHR, sampled every step
//  data_out   out  WIDTH   register contents
//  ser_out    out  1       bit shifted out on the most recent step
//  busy       out  1       multi-step command in progress
//  done       out  1       one-cycle pulse: command finished
// BEHAVIOUR
//  Reset (reset==0 at posedge): data_out=0, ser_out=0, busy=0, done=0, state=IDLE. Reset wins
//   over everything, including mid-command; the in-flight command is discarded.
//  enable==0: no state, counter, data_out, ser_out or done change; cmd_ready=0.
//  Ops: 000 NOP, 001 LOAD, 010 SHL (lsb<=ser_in, ser_out<=msb), 011 SHR (msb<=ser_in,
//   ser_out<=lsb), 100 ASR (msb kept, ser_out<=lsb), 101 ROL, 110 ROR, 111 CLR (data_out<=0).
//  FSM: IDLE, SHIFT.
//   IDLE + accept (cmd_valid && cmd_ready):
//    NOP/LOAD/CLR, or shift op with amt==0: apply in 1 edge; done=1 next cycle; stay IDLE.
//    Shift op with amt==1: first step at accept edge; done=1 next cycle; stay IDLE.
//    Shift op with amt>=2: first step at accept edge; cnt<=amt-1; ->SHIFT; busy=1.
//   SHIFT: one step per enabled edge, cnt--. Step with cnt==1 is last: ->IDLE, busy=0, done=1.
//  Latency: result of amt=N visible after N enabled edges from accept (1 for non-shift ops).
//  done is high for exactly one enabled cycle; cmd_ready is high in that same cycle, so
//   back-to-back commands sustain full throughput.
//  cmd_op/cmd_amt/data_in are sampled at accept only; ser_in is sampled on every step.
//  ser_out updates only on shift/rotate steps; holds across NOP/LOAD/CLR.
//  Amount is taken literally: steps > WIDTH on SHL/SHR fill entirely with ser_in;
//   ROL/ROR by WIDTH restore the original value.
// CONFIGURATION
//  SHIFT_REG_ROTATE_EN defined: ROL/ROR execute as above.
//  Not defined: rotate logic is removed; ops 101/110 behave as NOP (accepted, data_out and
//   ser_out unchanged, done after 1 cycle, no busy).
// STRUCTURE
//  shift_reg_pkg: typedef enum logic [2:0] shift_op_e {OP_NOP..OP_CLR};
//   typedef enum logic state_e {ST_IDLE, ST_SHIFT}; function is_shift_op(shift_op_e).
//  Sub-module shift_step: combinational single-bit step (op, data, ser_in -> data_nxt,
//   bit_out). The top holds the FSM, counter and registers.
// TESTING (WIDTH=8)
//  1 reset=0 for 2 cycles mid-anything -> data_out=00, busy=0, done=0, cmd_ready=1.
//  2 LOAD data_in=A5 -> next cycle data_out=A5, done=1 for one cycle, busy never 1.
//  3 from A5: SHL amt=3, ser_in=1 -> busy for 2 cycles, ser_out 1,0,1, data_out=2F, done once.
//  4 from 90: ASR amt=2 -> data_out=E4, ser_out=0; then SHR amt=0 -> unchanged, done next cycle.
//  5 from A5: ROR amt=4 -> 5A with SHIFT_REG_ROTATE_EN; without it -> A5, done after 1 cycle.
//  6 SHR amt=5 on FF, ser_in=0, enable low 2 cycles mid-run -> done 2 cycles late, data_out=07;
//    repeat with reset=0 at step 3 -> 00, IDLE, no done pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register family.
// Rotate support in the datapath is controlled by SHIFT_REG_ROTATE_EN.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } shift_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for every op that moves bits one position per step.
  function automatic logic is_shift_op(shift_op_e op);
    return op inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR};
  endfunction

  // True for the two circular ops, which can be compiled out.
  function automatic logic is_rotate_op(shift_op_e op);
    return op inside {OP_ROL, OP_ROR};
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the universal shift register.
// ROL/ROR are only built when SHIFT_REG_ROTATE_EN is defined; otherwise they pass data through.
import shift_reg_pkg::*;

module shift_step #(
  parameter int WIDTH = 8
) (
  input  shift_op_e          op,
  input  logic [WIDTH-1:0]   data,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   data_nxt,
  output logic               bit_out
);

  // One-position move for the selected op; non-shift ops leave the word untouched.
  always_comb begin
    data_nxt = data;
    bit_out  = 1'b0;
    case (op)
      OP_SHL: begin
        data_nxt = {data[WIDTH-2:0], ser_in};
        bit_out  = data[WIDTH-1];
      end
      OP_SHR: begin
        data_nxt = {ser_in, data[WIDTH-1:1]};
        bit_out  = data[0];
      end
      OP_ASR: begin
        data_nxt = {data[WIDTH-1], data[WIDTH-1:1]};
        bit_out  = data[0];
      end
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROL: begin
        data_nxt = {data[WIDTH-2:0], data[WIDTH-1]};
        bit_out  = data[WIDTH-1];
      end
      OP_ROR: begin
        data_nxt = {data[0], data[WIDTH-1:1]};
        bit_out  = data[0];
      end
`endif
      default: begin
        data_nxt = data;
        bit_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: accepts an (op, amount) command over valid/ready and
// executes it one bit per enabled cycle, reporting busy/done and a serial-out tap.
// Build option: SHIFT_REG_ROTATE_EN enables ROL/ROR; without it those ops act as NOP.
import shift_reg_pkg::*;

module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [AMT_W-1:0]   cmd_amt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  state_e            state_q, state_nxt;
  shift_op_e         op_q, op_nxt;
  logic [AMT_W-1:0]  cnt_q, cnt_nxt;
  logic [WIDTH-1:0]  data_q, data_nxt;
  logic              ser_q, ser_nxt;
  logic              done_q, done_nxt;

  shift_op_e         op_in;
  shift_op_e         step_op;
  logic              op_steps;
  logic [WIDTH-1:0]  step_data;
  logic              step_bit;

  assign op_in = shift_op_e'(cmd_op);

  // Rotates only count as stepping ops when the rotate datapath exists.
`ifdef SHIFT_REG_ROTATE_EN
  assign op_steps = is_shift_op(op_in);
`else
  assign op_steps = is_shift_op(op_in) && !is_rotate_op(op_in);
`endif

  // The first step happens on the accept edge, so IDLE steers the live command op;
  // later steps use the op captured at accept.
  assign step_op = (state_q == ST_SHIFT) ? op_q : op_in;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (step_op),
    .data     (data_q),
    .ser_in   (ser_in),
    .data_nxt (step_data),
    .bit_out  (step_bit)
  );

  assign cmd_ready = (state_q == ST_IDLE) && enable;
  assign busy      = (state_q == ST_SHIFT);
  assign done      = done_q;
  assign data_out  = data_q;
  assign ser_out   = ser_q;

  // Next-state logic: everything holds while enable is low; done is a single-cycle pulse.
  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    ser_nxt   = ser_q;
    done_nxt  = done_q;
    if (enable) begin
      done_nxt = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (op_steps) begin
              if (cmd_amt == '0) begin
                done_nxt = 1'b1;
              end else begin
                data_nxt = step_data;
                ser_nxt  = step_bit;
                if (cmd_amt == AMT_W'(1)) begin
                  done_nxt = 1'b1;
                end else begin
                  cnt_nxt   = cmd_amt - AMT_W'(1);
                  op_nxt    = op_in;
                  state_nxt = ST_SHIFT;
                end
              end
            end else begin
              if (op_in == OP_LOAD) begin
                data_nxt = data_in;
              end else if (op_in == OP_CLR) begin
                data_nxt = '0;
              end
              done_nxt = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data_nxt = step_data;
          ser_nxt  = step_bit;
          cnt_nxt  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset that discards any in-flight command.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      cnt_q   <= cnt_nxt;
      data_q  <= data_nxt;
      ser_q   <= ser_nxt;
      done_q  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8). Honours SHIFT_REG_ROTATE_EN like the design.
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_LOAD = 3'b001;
  localparam logic [2:0] C_SHL  = 3'b010;
  localparam logic [2:0] C_SHR  = 3'b011;
  localparam logic [2:0] C_ASR  = 3'b100;
  localparam logic [2:0] C_ROL  = 3'b101;
  localparam logic [2:0] C_ROR  = 3'b110;
  localparam logic [2:0] C_CLR  = 3'b111;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AMT_W-1:0]  cmd_amt;
  logic [WIDTH-1:0]  data_in;
  logic              ser_in;
  logic [WIDTH-1:0]  data_out;
  logic              ser_out;
  logic              busy;
  logic              done;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ser;
    int               lat;
    logic [15:0]      seq;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_data;
  logic             m_ser;
  int               total;
  int               bad;

  shift_reg_univ #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .data_in   (data_in),
    .ser_in    (ser_in),
    .data_out  (data_out),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rotate_built();
`ifdef SHIFT_REG_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: predicts final word, serial tap, latency and per-cycle ser_out trace.
  task automatic applyStimulus(input logic [2:0] op, input int amt,
                               input logic [WIDTH-1:0] din, input logic sin);
    exp_t e;
    logic steps;
    logic b;
    int   w;
    steps = (op == C_SHL) || (op == C_SHR) || (op == C_ASR) ||
            (rotate_built() && ((op == C_ROL) || (op == C_ROR)));
    e.seq = '0;
    if (steps && amt > 0) begin
      for (int i = 0; i < amt; i++) begin
        b = 1'b0;
        case (op)
          C_SHL: begin b = m_data[7]; m_data = {m_data[6:0], sin}; end
          C_SHR: begin b = m_data[0]; m_data = {sin, m_data[7:1]}; end
          C_ASR: begin b = m_data[0]; m_data = 8'($signed(m_data) >>> 1); end
          C_ROL: begin b = m_data[7]; m_data = {m_data[6:0], m_data[7]}; end
          C_ROR: begin b = m_data[0]; m_data = {m_data[0], m_data[7:1]}; end
          default: b = m_ser;
        endcase
        m_ser = b;
        e.seq = {e.seq[14:0], b};
      end
      e.lat = amt;
    end else begin
      if (op == C_LOAD) m_data = din;
      else if (op == C_CLR) m_data = '0;
      e.seq = {15'b0, m_ser};
      e.lat = 1;
    end
    e.data = m_data;
    e.ser  = m_ser;
    sb.push_back(e);

    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    compare("cmd_ready before issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = AMT_W'(amt);
    data_in   = din;
    ser_in    = sin;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    data_in   = '0;
  endtask

  // Waits for done (bounded), optionally stalling enable, then checks against the scoreboard.
  task automatic checkOutput(input string tag, input int stall_at, input int stall_len);
    exp_t             e;
    int               cyc;
    int               busy_cnt;
    int               busy_exp;
    logic [15:0]      seq;
    logic [WIDTH-1:0] prev;
    logic             seen;
    logic             frozen;
    cyc = 0;
    busy_cnt = 0;
    seq = '0;
    seen = 1'b0;
    if (sb.size() == 0) begin
      compare({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    while (!seen && cyc < 40) begin
      prev = data_out;
      @(negedge clk);
      cyc++;
      frozen = !enable;
      if (frozen) compare({tag, " hold while disabled"}, data_out, prev);
      if (stall_len > 0 && cyc == stall_at) enable = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) enable = 1'b1;
      if (busy) busy_cnt++;
      if (!frozen) seq = {seq[14:0], ser_out};
      if (done) seen = 1'b1;
    end
    enable = 1'b1;
    busy_exp = ((e.lat >= 2) ? e.lat - 1 : 0) + stall_len;
    compare({tag, " done seen"}, seen, 1'b1);
    compare({tag, " latency"}, cyc, e.lat + stall_len);
    compare({tag, " busy cycles"}, busy_cnt, busy_exp);
    compare({tag, " data_out"}, data_out, e.data);
    compare({tag, " ser_out"}, ser_out, e.ser);
    compare({tag, " ser_out trace"}, seq, e.seq);
    compare({tag, " ready with done"}, cmd_ready, 1'b1);
    @(negedge clk);
    compare({tag, " done single pulse"}, done, 1'b0);
  endtask

  // Holds reset low for n edges, then checks the cleared state.
  task automatic resetPulse(input string tag, input int n);
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_data = '0;
    m_ser  = 1'b0;
    compare({tag, " data_out"}, data_out, 8'h00);
    compare({tag, " ser_out"}, ser_out, 1'b0);
    compare({tag, " busy"}, busy, 1'b0);
    compare({tag, " done"}, done, 1'b0);
    compare({tag, " cmd_ready"}, cmd_ready, 1'b1);
  endtask

  // Directed sequence.
  initial begin
    int dn;
    total = 0;
    bad = 0;
    m_data = '0;
    m_ser = 1'b0;
    reset = 1'b0;
    enable = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = C_NOP;
    cmd_amt = '0;
    data_in = '0;
    ser_in = 1'b0;

    $display("[TB] start, rotate=%0d", rotate_built());
    resetPulse("power-up reset", 2);

    applyStimulus(C_LOAD, 0, 8'hA5, 1'b0);
    checkOutput("load A5", 0, 0);
    applyStimulus(C_SHL, 3, 8'h00, 1'b1);
    checkOutput("shl3 A5", 0, 0);

    applyStimulus(C_LOAD, 0, 8'h90, 1'b0);
    checkOutput("load 90", 0, 0);
    applyStimulus(C_ASR, 2, 8'h00, 1'b1);
    checkOutput("asr2 90", 0, 0);
    applyStimulus(C_SHR, 0, 8'h00, 1'b1);
    checkOutput("shr0 E4", 0, 0);

    applyStimulus(C_LOAD, 0, 8'hA5, 1'b0);
    checkOutput("load A5 again", 0, 0);
    applyStimulus(C_ROR, 4, 8'h00, 1'b0);
    checkOutput("ror4 A5", 0, 0);

    applyStimulus(C_LOAD, 0, 8'hB4, 1'b0);
    checkOutput("load B4", 0, 0);
    applyStimulus(C_ROL, 8, 8'h00, 1'b0);
    checkOutput("rol8 B4", 0, 0);

    applyStimulus(C_LOAD, 0, 8'h3C, 1'b0);
    checkOutput("load 3C", 0, 0);
    applyStimulus(C_SHL, 12, 8'h00, 1'b1);
    checkOutput("shl12 fill", 0, 0);
    applyStimulus(C_NOP, 3, 8'h55, 1'b0);
    checkOutput("nop", 0, 0);
    applyStimulus(C_CLR, 0, 8'h55, 1'b1);
    checkOutput("clr", 0, 0);

    applyStimulus(C_LOAD, 0, 8'hFF, 1'b0);
    checkOutput("load FF", 0, 0);
    applyStimulus(C_SHR, 5, 8'h00, 1'b0);
    checkOutput("shr5 stall", 2, 2);

    applyStimulus(C_LOAD, 0, 8'hFF, 1'b0);
    checkOutput("load FF again", 0, 0);
    applyStimulus(C_SHR, 5, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_data = '0;
    m_ser = 1'b0;
    compare("reset at step3 data_out", data_out, 8'h00);
    compare("reset at step3 busy", busy, 1'b0);
    compare("reset at step3 cmd_ready", cmd_ready, 1'b1);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    compare("reset at step3 no done", dn, 0);

    applyStimulus(C_LOAD, 0, 8'h3C, 1'b0);
    checkOutput("load 3C again", 0, 0);
    applyStimulus(C_SHL, 7, 8'h00, 1'b1);
    @(negedge clk);
    resetPulse("reset mid-shift", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
